// File: rtl/ldm_stm_sequencer.sv
// Sequences an LDM/STM block transfer one word per memory handshake, lowest
// register at the lowest address, with optional base-register writeback.
module ldm_stm_sequencer #(
    parameter int REG_LIST_W = 16,
    parameter int ADDR_STEP  = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic                  Is_load,
    input  logic                  P_bit,
    input  logic                  U_bit,
    input  logic                  W_bit,
    input  logic [REG_LIST_W-1:0] Reg_list,
    input  logic [4:0]            Base_reg,
    input  logic [31:0]           Base_val,
    output logic [4:0]            Rd_r_addr,
    input  logic [31:0]           Rd_out,
    output logic [4:0]            Rd_w_addr,
    output logic [31:0]           Rd_in,
    output logic [3:0]            Rd_byte_w_en,
    output logic [4:0]            Rn_w_addr,
    output logic [31:0]           Rn_in,
    output logic [3:0]            Rn_byte_w_en,
    output logic                  Mem_req,
    output logic                  Mem_we,
    output logic [31:0]           Mem_addr,
    output logic [31:0]           Mem_wdata,
    input  logic                  Mem_ready,
    input  logic [31:0]           Mem_rdata,
    output logic                  Busy,
    output logic                  Done
);
    localparam int          CNT_W = $clog2(REG_LIST_W + 1);
    localparam logic [31:0] STEP  = 32'(ADDR_STEP);

    typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic                  r_isLoad;
    logic                  r_wbEn;
    logic [4:0]            r_baseReg;
    logic [31:0]           r_wbVal;
    logic [31:0]           r_addr;
    logic [REG_LIST_W-1:0] r_mask;

    logic [CNT_W-1:0]      w_count;
    logic                  w_rnInList;
    logic [31:0]           w_span;
    logic [31:0]           w_startAddr;
    logic [4:0]            w_cur;
    logic [REG_LIST_W-1:0] w_maskNext;

    // Decode the command at Start: word count, start address and whether a
    // load would overwrite the base register (which suppresses writeback).
    always_comb begin
        w_count    = '0;
        w_rnInList = 1'b0;
        for (int i = 0; i < REG_LIST_W; i++) begin
            w_count = w_count + CNT_W'(Reg_list[i]);
            if (Reg_list[i] && (Base_reg == 5'(i))) begin
                w_rnInList = 1'b1;
            end
        end
        w_span = 32'(w_count) * STEP;
        case ({P_bit, U_bit})
            2'b01:   w_startAddr = Base_val;
            2'b11:   w_startAddr = Base_val + STEP;
            2'b00:   w_startAddr = Base_val - w_span + STEP;
            default: w_startAddr = Base_val - w_span;
        endcase
    end

    always_comb begin
        w_cur = '0;
        for (int i = REG_LIST_W - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_cur = 5'(i);
            end
        end
        w_maskNext = r_mask & (r_mask - REG_LIST_W'(1));
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: if (Start) w_stateNext = (Reg_list != '0) ? XFER : FIN;
            XFER: if (Mem_ready && (w_maskNext == '0)) w_stateNext = FIN;
            FIN:  w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= IDLE;
            r_mask    <= '0;
            r_addr    <= '0;
            r_isLoad  <= 1'b0;
            r_wbEn    <= 1'b0;
            r_baseReg <= '0;
            r_wbVal   <= '0;
        end else begin
            r_state <= w_stateNext;
            if ((r_state == IDLE) && Start) begin
                r_mask    <= Reg_list;
                r_addr    <= w_startAddr;
                r_isLoad  <= Is_load;
                r_baseReg <= Base_reg;
                r_wbEn    <= W_bit && (Reg_list != '0) && !(Is_load && w_rnInList);
                r_wbVal   <= U_bit ? (Base_val + w_span) : (Base_val - w_span);
            end else if ((r_state == XFER) && Mem_ready) begin
                r_mask <= w_maskNext;
                r_addr <= r_addr + STEP;
            end
        end
    end

    // Request outputs follow the current state only, so they stay put while
    // memory stalls; load write-back is the only path gated by Mem_ready.
    always_comb begin
        Busy         = (r_state != IDLE);
        Done         = (r_state == FIN);
        Mem_req      = 1'b0;
        Mem_we       = 1'b0;
        Mem_addr     = '0;
        Mem_wdata    = '0;
        Rd_r_addr    = '0;
        Rd_w_addr    = '0;
        Rd_in        = '0;
        Rd_byte_w_en = 4'h0;
        Rn_w_addr    = '0;
        Rn_in        = '0;
        Rn_byte_w_en = 4'h0;
        if (r_state == XFER) begin
            Mem_req  = 1'b1;
            Mem_addr = r_addr;
            if (r_isLoad) begin
                if (Mem_ready) begin
                    Rd_w_addr    = w_cur;
                    Rd_in        = Mem_rdata;
                    Rd_byte_w_en = 4'hF;
                end
            end else begin
                Rd_r_addr = w_cur;
                Mem_we    = 1'b1;
                Mem_wdata = Rd_out;
            end
        end
        if ((r_state == FIN) && r_wbEn) begin
            Rn_w_addr    = r_baseReg;
            Rn_in        = r_wbVal;
            Rn_byte_w_en = 4'hF;
        end
    end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: a queue-of-transfers model checked every cycle,
// directed scenarios with literal expectations, then randomized commands.
module tb_ldm_stm_sequencer;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic        Is_load = 1'b0;
    logic        P_bit = 1'b0;
    logic        U_bit = 1'b0;
    logic        W_bit = 1'b0;
    logic [15:0] Reg_list = '0;
    logic [4:0]  Base_reg = '0;
    logic [31:0] Base_val = '0;
    logic        Mem_ready = 1'b0;
    logic [4:0]  Rd_r_addr, Rd_w_addr, Rn_w_addr;
    logic [31:0] Rd_out, Rd_in, Rn_in, Mem_addr, Mem_wdata, Mem_rdata;
    logic [3:0]  Rd_byte_w_en, Rn_byte_w_en;
    logic        Mem_req, Mem_we, Busy, Done;

    ldm_stm_sequencer dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Is_load(Is_load),
        .P_bit(P_bit), .U_bit(U_bit), .W_bit(W_bit), .Reg_list(Reg_list),
        .Base_reg(Base_reg), .Base_val(Base_val), .Rd_r_addr(Rd_r_addr),
        .Rd_out(Rd_out), .Rd_w_addr(Rd_w_addr), .Rd_in(Rd_in),
        .Rd_byte_w_en(Rd_byte_w_en), .Rn_w_addr(Rn_w_addr), .Rn_in(Rn_in),
        .Rn_byte_w_en(Rn_byte_w_en), .Mem_req(Mem_req), .Mem_we(Mem_we),
        .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata), .Mem_ready(Mem_ready),
        .Mem_rdata(Mem_rdata), .Busy(Busy), .Done(Done)
    );

    initial forever #5 Clk = ~Clk;

    function automatic logic [31:0] regVal(input logic [4:0] r);
        return 32'hCAFE_0000 | (32'(r) * 32'h111);
    endfunction

    function automatic logic [31:0] memVal(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign Rd_out    = regVal(Rd_r_addr);
    assign Mem_rdata = memVal(Mem_addr);

    int numChecks = 0;
    int numFails  = 0;
    int cycle     = 0;
    int startCycle, idleCycle;
    int readyMode = 0;
    int stallLeft = 0;

    logic        mBusy = 1'b0, mFin = 1'b0, mIsLoad = 1'b0, mWbEn = 1'b0;
    logic [4:0]  mBaseReg = '0;
    logic [31:0] mWbVal = '0;
    int          qReg[$];
    logic [31:0] qAddr[$];

    logic [31:0] logAddr[$], logWdata[$], logRdData[$];
    logic [4:0]  logWReg[$];
    int          wbCount = 0, doneCount = 0, doneCycle = -1;
    logic [4:0]  wbAddr = '0;
    logic [31:0] wbVal = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // The model builds the whole ordered transfer list at Start from plain
    // address arithmetic, then pops one entry per accepted memory handshake.
    task automatic startModel();
        int          n;
        logic [31:0] span, lowest;
        bit          rnIn;
        n    = $countones(Reg_list);
        span = 32'(n) * 32'd4;
        if (U_bit) lowest = P_bit ? Base_val + 32'd4 : Base_val;
        else       lowest = P_bit ? Base_val - span : Base_val - span + 32'd4;
        qReg.delete();
        qAddr.delete();
        rnIn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (Reg_list[i]) begin
                qAddr.push_back(lowest + 32'(4 * qReg.size()));
                qReg.push_back(i);
                if (i == int'(Base_reg)) rnIn = 1'b1;
            end
        end
        mIsLoad  = Is_load;
        mBaseReg = Base_reg;
        mWbEn    = W_bit && (n != 0) && !(Is_load && rnIn);
        mWbVal   = U_bit ? Base_val + span : Base_val - span;
        mBusy    = 1'b1;
        mFin     = (n == 0);
    endtask

    initial forever begin
        @(posedge Clk or posedge Rst);
        if (Rst) begin
            mBusy = 1'b0;
            mFin  = 1'b0;
            qReg.delete();
            qAddr.delete();
        end else if (!mBusy) begin
            if (Start) startModel();
        end else if (mFin) begin
            mBusy = 1'b0;
            mFin  = 1'b0;
        end else if (Mem_ready) begin
            void'(qReg.pop_front());
            void'(qAddr.pop_front());
            if (qReg.size() == 0) mFin = 1'b1;
        end
    end

    initial forever begin
        @(posedge Clk);
        cycle++;
    end

    initial forever begin
        @(posedge Clk);
        #1;
        case (readyMode)
            0: Mem_ready = 1'b1;
            1: Mem_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if ((logAddr.size() == 1) && (stallLeft > 0)) begin
                    Mem_ready = 1'b0;
                    stallLeft--;
                end else begin
                    Mem_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic compareCycle();
        logic        expReq, expWe, expRdWr, expWb;
        logic [31:0] expAddr, expWdata, expRdIn;
        logic [4:0]  expRAddr, expWAddr;
        expReq = 1'b0; expWe = 1'b0; expRdWr = 1'b0;
        expAddr = '0; expWdata = '0; expRdIn = '0; expRAddr = '0; expWAddr = '0;
        if (!Rst && mBusy && !mFin) begin
            expReq  = 1'b1;
            expAddr = qAddr[0];
            if (mIsLoad) begin
                if (Mem_ready) begin
                    expRdWr  = 1'b1;
                    expWAddr = 5'(qReg[0]);
                    expRdIn  = memVal(qAddr[0]);
                end
            end else begin
                expWe    = 1'b1;
                expRAddr = 5'(qReg[0]);
                expWdata = regVal(5'(qReg[0]));
            end
        end
        expWb = !Rst && mFin && mWbEn;
        checkOutput("Busy", 32'(Busy), 32'(!Rst && mBusy));
        checkOutput("Done", 32'(Done), 32'(!Rst && mFin));
        checkOutput("Mem_req", 32'(Mem_req), 32'(expReq));
        checkOutput("Mem_we", 32'(Mem_we), 32'(expWe));
        checkOutput("Mem_addr", Mem_addr, expAddr);
        checkOutput("Mem_wdata", Mem_wdata, expWdata);
        checkOutput("Rd_r_addr", 32'(Rd_r_addr), 32'(expRAddr));
        checkOutput("Rd_w_addr", 32'(Rd_w_addr), 32'(expWAddr));
        checkOutput("Rd_in", Rd_in, expRdIn);
        checkOutput("Rd_byte_w_en", 32'(Rd_byte_w_en), expRdWr ? 32'hF : 32'h0);
        checkOutput("Rn_w_addr", 32'(Rn_w_addr), expWb ? 32'(mBaseReg) : 32'h0);
        checkOutput("Rn_in", Rn_in, expWb ? mWbVal : 32'h0);
        checkOutput("Rn_byte_w_en", 32'(Rn_byte_w_en), expWb ? 32'hF : 32'h0);
        if (!Rst) begin
            if (Mem_req && Mem_ready) begin
                logAddr.push_back(Mem_addr);
                if (Mem_we) logWdata.push_back(Mem_wdata);
            end
            if (Rd_byte_w_en == 4'hF) begin
                logWReg.push_back(Rd_w_addr);
                logRdData.push_back(Rd_in);
            end
            if (Rn_byte_w_en == 4'hF) begin
                wbCount++;
                wbAddr = Rn_w_addr;
                wbVal  = Rn_in;
            end
            if (Done) begin
                doneCount++;
                doneCycle = cycle;
            end
        end
    endtask

    initial forever begin
        @(negedge Clk);
        compareCycle();
    end

    task automatic clearLogs();
        logAddr.delete();
        logWdata.delete();
        logWReg.delete();
        logRdData.delete();
        wbCount   = 0;
        doneCount = 0;
        doneCycle = -1;
    endtask

    // Called one time unit after a rising edge with the DUT idle; returns the
    // same way once Busy has dropped (or after a bounded wait).
    task automatic applyStimulus(input logic isLoad, input logic p, input logic u, input logic w,
                                 input logic [15:0] list, input logic [4:0] baseReg,
                                 input logic [31:0] baseVal);
        int k;
        clearLogs();
        Is_load = isLoad; P_bit = p; U_bit = u; W_bit = w;
        Reg_list = list; Base_reg = baseReg; Base_val = baseVal;
        Start = 1'b1;
        startCycle = cycle;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        for (k = 0; (k < 300) && Busy; k++) begin
            @(posedge Clk);
            #1;
        end
        idleCycle = cycle;
        checkOutput("idle_after_transfer", 32'(Busy), 32'h0);
        if (Busy) begin
            Rst = 1'b1;
            @(posedge Clk);
            #1;
            Rst = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("rst_Busy", 32'(Busy), 32'h0);
        checkOutput("rst_Done", 32'(Done), 32'h0);
        checkOutput("rst_Mem_req", 32'(Mem_req), 32'h0);
        checkOutput("rst_Rd_byte_w_en", 32'(Rd_byte_w_en), 32'h0);
        checkOutput("rst_Rn_byte_w_en", 32'(Rn_byte_w_en), 32'h0);
        Rst = 1'b0;
        @(posedge Clk);
        #1;

        // STM IA with writeback, memory always ready
        readyMode = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h000E, 5'd13, 32'h0000_1000);
        checkOutput("stmia_words", 32'(logAddr.size()), 32'd3);
        checkOutput("stmia_addr0", logAddr[0], 32'h0000_1000);
        checkOutput("stmia_addr1", logAddr[1], 32'h0000_1004);
        checkOutput("stmia_addr2", logAddr[2], 32'h0000_1008);
        checkOutput("stmia_data0", logWdata[0], 32'hCAFE_0111);
        checkOutput("stmia_data2", logWdata[2], 32'hCAFE_0333);
        checkOutput("stmia_wb_addr", 32'(wbAddr), 32'd13);
        checkOutput("stmia_wb_val", wbVal, 32'h0000_100C);
        checkOutput("stmia_done_cycle", 32'(doneCycle - startCycle), 32'd4);
        checkOutput("stmia_idle_cycle", 32'(idleCycle - startCycle), 32'd5);

        // LDM DB with writeback
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h8001, 5'd13, 32'h0000_2000);
        checkOutput("ldmdb_addr0", logAddr[0], 32'h0000_1FF8);
        checkOutput("ldmdb_addr1", logAddr[1], 32'h0000_1FFC);
        checkOutput("ldmdb_reg0", 32'(logWReg[0]), 32'd0);
        checkOutput("ldmdb_reg1", 32'(logWReg[1]), 32'd15);
        checkOutput("ldmdb_data0", logRdData[0], 32'h5A5A_1FF8);
        checkOutput("ldmdb_wb_val", wbVal, 32'h0000_1FF8);

        // LDM IA with the base register in the list: loaded value wins
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h2010, 5'd4, 32'h0000_5000);
        checkOutput("ldm_rn_reg0", 32'(logWReg[0]), 32'd4);
        checkOutput("ldm_rn_data0", logRdData[0], 32'h5A5A_5000);
        checkOutput("ldm_rn_no_wb", 32'(wbCount), 32'd0);

        // Three-cycle stall on the second word
        stallLeft = 3;
        readyMode = 2;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0007, 5'd2, 32'h0000_3000);
        checkOutput("stall_done_cycle", 32'(doneCycle - startCycle), 32'd7);
        checkOutput("stall_addr1", logAddr[1], 32'h0000_3004);
        checkOutput("stall_data1", logWdata[1], 32'hCAFE_0111);
        readyMode = 0;

        // Empty list with writeback requested, plus a Start while busy
        clearLogs();
        Is_load = 1'b0; P_bit = 1'b0; U_bit = 1'b1; W_bit = 1'b1;
        Reg_list = 16'h0000; Base_reg = 5'd13; Base_val = 32'h0000_6000;
        Start = 1'b1;
        startCycle = cycle;
        @(posedge Clk);
        #1;
        checkOutput("empty_done", 32'(Done), 32'h1);
        Reg_list = 16'h0003;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        checkOutput("empty_busy_ignored", 32'(Busy), 32'h0);
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("empty_no_mem", 32'(logAddr.size()), 32'd0);
        checkOutput("empty_no_wb", 32'(wbCount), 32'd0);
        checkOutput("empty_done_count", 32'(doneCount), 32'd1);
        checkOutput("empty_done_cycle", 32'(doneCycle - startCycle), 32'd1);

        // Reset during the second of four LDM words
        clearLogs();
        Is_load = 1'b1; P_bit = 1'b0; U_bit = 1'b1; W_bit = 1'b1;
        Reg_list = 16'h00F0; Base_reg = 5'd2; Base_val = 32'h0000_7000;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(posedge Clk);
        #2;
        Rst = 1'b1;
        #1;
        checkOutput("abort_Busy", 32'(Busy), 32'h0);
        checkOutput("abort_Mem_req", 32'(Mem_req), 32'h0);
        checkOutput("abort_Rd_byte_w_en", 32'(Rd_byte_w_en), 32'h0);
        checkOutput("abort_Mem_addr", Mem_addr, 32'h0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        checkOutput("abort_writes", 32'(logWReg.size()), 32'd1);
        checkOutput("abort_first_reg", 32'(logWReg[0]), 32'd4);
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        checkOutput("abort_no_wb", 32'(wbCount), 32'd0);
        checkOutput("abort_idle", 32'(Busy), 32'h0);

        readyMode = 1;
        for (int t = 0; t < 40; t++) begin
            logic [15:0] list;
            logic [31:0] base;
            list = 16'($urandom);
            if ($urandom_range(0, 7) == 0) list = '0;
            else if ($urandom_range(0, 2) == 0) list = list & 16'($urandom);
            base = 32'($urandom) & 32'hFFFF_FFFC;
            if ((t % 5) == 0) base = 32'h0000_0008;
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          list, 5'($urandom_range(0, 17)), base);
            repeat ($urandom_range(0, 2)) begin
                @(posedge Clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule
